squarewave_det: RTL

- Receive-side counterpart of the square-wave pulse generator.
- Synchronizes an asynchronous pulse input, measures the high time in CLK cycles, and classifies each pulse against a nominal width and tolerance.
- Sits at the board input that accepts trigger/sync pulses from a remote generator. Results go to the register map / DAQ logic as a one-cycle report strobe with held result registers.

---
 rtl/squarewave_det_pkg.sv | 30 +++
 rtl/squarewave_det_level_sync.sv | 33 +++
 rtl/squarewave_det.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/squarewave_det_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : squarewave_det_pkg
// Purpose  : Shared constants and FSM state encoding for the square-wave
//            pulse detector. The default pulse width and tolerance are shared
//            with the pulse generator so both ends agree on 1 ms at 100 MHz.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package squarewave_det_pkg;

    // Nominal pulse width in CLK cycles (1 ms at 100 MHz) and accept tolerance
    localparam int C_DEF_NOM_WIDTH   = 100000;
    localparam int C_DEF_TOL         = 1000;
    localparam int C_DEF_COUNT_WIDTH = 17;
    localparam int C_DEF_SYNC_STAGES = 2;

    // Width of the accepted-pulse counter
    localparam int C_OK_CNT_WIDTH    = 16;

    // Detector FSM state encoding
    localparam int C_STATE_W = 2;
    typedef logic [C_STATE_W-1:0] state_t;

    localparam state_t C_ST_ARM      = 2'd0;  // wait for input low after reset
    localparam state_t C_ST_IDLE     = 2'd1;  // armed, waiting for a rising edge
    localparam state_t C_ST_HIGH     = 2'd2;  // measuring high time
    localparam state_t C_ST_WAIT_LOW = 2'd3;  // over-long pulse reported, wait for fall

endpackage : squarewave_det_pkg
`default_nettype wire

// File: rtl/squarewave_det_level_sync.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : level_sync
// Purpose  : Multi-stage flop synchronizer for an asynchronous level input.
//            The chain resets to a programmable value so the downstream logic
//            sees a known, safe level while reset is asserted.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module level_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // Shift the asynchronous input through the synchronizer chain
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync <= {STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule : level_sync
`default_nettype wire

// File: rtl/squarewave_det.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : squarewave_det
// Purpose  : Receive-side square-wave pulse detector. Synchronizes an
//            asynchronous pulse input, measures its high time in CLK cycles
//            and classifies each pulse as OK / SHORT / LONG against a nominal
//            width and tolerance. Results are held until the next report.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module squarewave_det
    import squarewave_det_pkg::*;
#(
    parameter int COUNT_WIDTH = C_DEF_COUNT_WIDTH,
    parameter int NOM_WIDTH   = C_DEF_NOM_WIDTH,
    parameter int TOL         = C_DEF_TOL,
    parameter int SYNC_STAGES = C_DEF_SYNC_STAGES
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      D,
    output logic                      RISE,
    output logic                      DONE,
    output logic [COUNT_WIDTH-1:0]    WIDTH,
    output logic                      OK,
    output logic                      SHORT,
    output logic                      LONG,
    output logic [C_OK_CNT_WIDTH-1:0] OK_CNT
);

    // Measurement limits expressed in counter width. The counter saturates at
    // C_LIMIT, so an over-long pulse is reported as one past the limit.
    localparam logic [COUNT_WIDTH-1:0] C_LIMIT  = COUNT_WIDTH'(NOM_WIDTH + TOL);
    localparam logic [COUNT_WIDTH-1:0] C_LONG_W = COUNT_WIDTH'(NOM_WIDTH + TOL + 1);
    localparam logic [COUNT_WIDTH-1:0] C_MIN_OK = COUNT_WIDTH'(NOM_WIDTH - TOL);
    localparam logic [COUNT_WIDTH-1:0] C_ONE    = COUNT_WIDTH'(1);

    // Synchronized input level
    logic w_s;

    // FSM state
    state_t r_state;
    state_t w_state_nxt;

    // Measurement counter
    logic [COUNT_WIDTH-1:0] r_cnt;
    logic [COUNT_WIDTH-1:0] w_cnt_nxt;

    // Per-cycle decisions from the output logic
    logic                   w_rise;
    logic                   w_report;
    logic [COUNT_WIDTH-1:0] w_rep_width;
    logic                   w_rep_long;
    logic                   w_rep_short;
    logic                   w_rep_ok;

    // Registered outputs
    logic                      r_rise;
    logic                      r_done;
    logic [COUNT_WIDTH-1:0]    r_width;
    logic                      r_ok;
    logic                      r_short;
    logic                      r_long;
    logic [C_OK_CNT_WIDTH-1:0] r_ok_cnt;

    //--------------------------------------------------------------------------
    // Input synchronizer; resets high so a pulse in progress at reset release
    // is never mistaken for a fresh rising edge.
    //--------------------------------------------------------------------------
    level_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync (
        .CLK (CLK),
        .RST (RST),
        .i_d (D),
        .o_q (w_s)
    );

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= C_ST_ARM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ST_ARM: begin
                if (!w_s) begin
                    w_state_nxt = C_ST_IDLE;
                end
            end
            C_ST_IDLE: begin
                if (w_s) begin
                    w_state_nxt = C_ST_HIGH;
                end
            end
            C_ST_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = C_ST_IDLE;
                end else if (r_cnt == C_LIMIT) begin
                    w_state_nxt = C_ST_WAIT_LOW;
                end
            end
            C_ST_WAIT_LOW: begin
                if (!w_s) begin
                    w_state_nxt = C_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = C_ST_ARM;
            end
        endcase
    end

    // FSM output logic: rise strobe, counter update and report decision
    always_comb begin
        w_rise      = 1'b0;
        w_report    = 1'b0;
        w_rep_width = r_cnt;
        w_rep_long  = 1'b0;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            C_ST_IDLE: begin
                if (w_s) begin
                    w_rise    = 1'b1;
                    w_cnt_nxt = C_ONE;
                end
            end
            C_ST_HIGH: begin
                if (!w_s) begin
                    // Pulse ended inside the measurable range
                    w_report    = 1'b1;
                    w_rep_width = r_cnt;
                end else if (r_cnt == C_LIMIT) begin
                    // Still high past the window: report LONG without waiting
                    w_report    = 1'b1;
                    w_rep_width = C_LONG_W;
                    w_rep_long  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            default: begin
                w_cnt_nxt = r_cnt;
            end
        endcase
    end

    // Classification of the width being reported this cycle
    always_comb begin
        w_rep_short = !w_rep_long && (w_rep_width < C_MIN_OK);
        w_rep_ok    = !w_rep_long && !w_rep_short;
    end

    // Counter, strobes and held result registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt    <= '0;
            r_rise   <= 1'b0;
            r_done   <= 1'b0;
            r_width  <= '0;
            r_ok     <= 1'b0;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_ok_cnt <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_rise <= w_rise;
            r_done <= w_report;
            if (w_report) begin
                r_width <= w_rep_width;
                r_ok    <= w_rep_ok;
                r_short <= w_rep_short;
                r_long  <= w_rep_long;
                if (w_rep_ok) begin
                    r_ok_cnt <= r_ok_cnt + 16'd1;
                end
            end
        end
    end

    assign RISE   = r_rise;
    assign DONE   = r_done;
    assign WIDTH  = r_width;
    assign OK     = r_ok;
    assign SHORT  = r_short;
    assign LONG   = r_long;
    assign OK_CNT = r_ok_cnt;

endmodule : squarewave_det
`default_nettype wire
